// File: rtl/dual_bridge_pkg.sv
// Shared types and constants for the dual bridge arbiter / RAM slave.
package dual_bridge_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int LANES  = DATA_W / 8;
  localparam int WORD_W = ADDR_W - 1;
  localparam int DEPTH  = 2 ** WORD_W;

  // Mailbox word owned by master0 (written by master1) and vice versa
  localparam logic [WORD_W-1:0] MBOX0_WORD = 10'h3FE;
  localparam logic [WORD_W-1:0] MBOX1_WORD = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Latched bridge request; addr is already the word index (byte bit 0 dropped)
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic              rw;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Mailbox word that raises the irq of the given owner master
  function automatic logic [WORD_W-1:0] mbox_word(input logic owner);
    return owner ? MBOX1_WORD : MBOX0_WORD;
  endfunction

endpackage

// File: rtl/bridge_ram_be.sv
// Single-port synchronous word RAM with byte-lane write enables, 1-cycle read.
module bridge_ram_be
  import dual_bridge_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Lane-masked write and registered read; contents are never reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (be_i[l]) mem_q[addr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dual_bridge_arbiter_ram.sv
// Round-robin arbiter for two Nios bridge masters onto one shared word RAM,
// with per-master acknowledge/read-data return and mailbox interrupts.
//
// Handshake: a master raises bus_enable with a stable request and holds it
// until it sees a one-cycle acknowledge; the transfer is complete on that
// cycle. The arbiter does not re-arbitrate until the served master has
// dropped bus_enable, so a held request is never served twice.
module dual_bridge_arbiter_ram
  import dual_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address_i,
  input  logic              m0_bus_enable_i,
  input  logic [LANES-1:0]  m0_byte_enable_i,
  input  logic              m0_rw_i,
  input  logic [DATA_W-1:0] m0_write_data_i,
  output logic [DATA_W-1:0] m0_read_data_o,
  output logic              m0_acknowledge_o,
  output logic              m0_irq_o,
  input  logic [ADDR_W-1:0] m1_address_i,
  input  logic              m1_bus_enable_i,
  input  logic [LANES-1:0]  m1_byte_enable_i,
  input  logic              m1_rw_i,
  input  logic [DATA_W-1:0] m1_write_data_i,
  output logic [DATA_W-1:0] m1_read_data_o,
  output logic              m1_acknowledge_o,
  output logic              m1_irq_o,
  output state_e            dbg_state_o
);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              ptr_q, ptr_d;
  logic              sel;
  req_t              req_q, req_d;
  req_t              req_in [2];
  logic [1:0]        bus_en;
  logic [1:0]        ack_q;
  logic [1:0]        irq_q;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic              ram_re;
  logic              unused_addr_lsb;

  assign bus_en    = {m1_bus_enable_i, m0_bus_enable_i};
  assign req_in[0] = '{addr: m0_address_i[ADDR_W-1:1], rw: m0_rw_i,
                       be: m0_byte_enable_i, wdata: m0_write_data_i};
  assign req_in[1] = '{addr: m1_address_i[ADDR_W-1:1], rw: m1_rw_i,
                       be: m1_byte_enable_i, wdata: m1_write_data_i};
  // Byte address bit 0 carries no meaning for a 16-bit word RAM
  assign unused_addr_lsb = m0_address_i[0] ^ m1_address_i[0];

  // Arbitration FSM: next state, grant, latched request and priority pointer
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    sel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus_en) begin
          sel     = (&bus_en) ? ptr_q : bus_en[1];
          gnt_d   = sel;
          req_d   = req_in[sel];
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = ACK;
      ACK: begin
        ptr_d   = ~gnt_q;
        state_d = RELEASE;
      end
      RELEASE: if (!bus_en[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and request registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
    end
  end

  // Gating the write with reset_n abandons a write caught by reset in ACCESS
  assign ram_we = (state_q == ACCESS) && !req_q.rw && reset_n;
  assign ram_re = (state_q == ACCESS) && req_q.rw;

  bridge_ram_be u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .be_i    (req_q.be),
    .addr_i  (req_q.addr),
    .wdata_i (req_q.wdata),
    .rdata_o (ram_rdata)
  );

  // Acknowledge pulse and read-data return to the granted master only
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      ack_q <= '0;
      if (state_q == ACK) begin
        ack_q[gnt_q] <= 1'b1;
        if (req_q.rw) rdata_q[gnt_q] <= ram_rdata;
      end
    end
  end

  // Sticky mailbox irqs: set by the other master's write, cleared by owner's read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((state_q == ACCESS) && !req_q.rw && (gnt_q != i[0]) &&
            (req_q.addr == mbox_word(i[0])))
          irq_q[i] <= 1'b1;
        if ((state_q == ACK) && req_q.rw && (gnt_q == i[0]) &&
            (req_q.addr == mbox_word(i[0])))
          irq_q[i] <= 1'b0;
      end
    end
  end

  assign m0_read_data_o   = rdata_q[0];
  assign m1_read_data_o   = rdata_q[1];
  assign m0_acknowledge_o = ack_q[0];
  assign m1_acknowledge_o = ack_q[1];
  assign m0_irq_o         = irq_q[0];
  assign m1_irq_o         = irq_q[1];
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_dual_bridge_arbiter_ram.sv
// Bench for dual_bridge_arbiter_ram: directed scenarios plus randomized
// single/contended traffic checked against a word-level memory model.
module tb_dual_bridge_arbiter_ram;
  import dual_bridge_pkg::*;

  typedef struct {
    logic [10:0] addr;
    logic        rw;
    logic [1:0]  be;
    logic [15:0] wdata;
  } tb_req_t;

  logic        clk;
  logic        reset_n;
  logic [10:0] m0_address, m1_address;
  logic        m0_bus_enable, m1_bus_enable;
  logic [1:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_rw, m1_rw;
  logic [15:0] m0_write_data, m1_write_data;
  logic [15:0] m0_read_data, m1_read_data;
  logic        m0_acknowledge, m1_acknowledge;
  logic        m0_irq, m1_irq;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected read_data of the acknowledged master, in ack order
  logic [15:0] exp_q[$];

  // Reference model: memory contents, written lanes, irqs, returned data, pointer
  logic [15:0] mdl_mem   [1024];
  logic [1:0]  mdl_lanes [1024];
  logic        mdl_irq   [2];
  logic [15:0] mdl_rd    [2];
  int          mdl_ptr;

  dual_bridge_arbiter_ram dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address_i     (m0_address),
    .m0_bus_enable_i  (m0_bus_enable),
    .m0_byte_enable_i (m0_byte_enable),
    .m0_rw_i          (m0_rw),
    .m0_write_data_i  (m0_write_data),
    .m0_read_data_o   (m0_read_data),
    .m0_acknowledge_o (m0_acknowledge),
    .m0_irq_o         (m0_irq),
    .m1_address_i     (m1_address),
    .m1_bus_enable_i  (m1_bus_enable),
    .m1_byte_enable_i (m1_byte_enable),
    .m1_rw_i          (m1_rw),
    .m1_write_data_i  (m1_write_data),
    .m1_read_data_o   (m1_read_data),
    .m1_acknowledge_o (m1_acknowledge),
    .m1_irq_o         (m1_irq),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Both acknowledges must never be high together
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (m0_acknowledge && m1_acknowledge) begin
        errors++;
        $display("FAIL ack_exclusive: m0_ack=%0b m1_ack=%0b, required not both 1",
                 m0_acknowledge, m1_acknowledge);
      end
    end
  end

  task automatic model_reset();
    mdl_irq[0] = 1'b0; mdl_irq[1] = 1'b0;
    mdl_rd[0]  = '0;   mdl_rd[1]  = '0;
    mdl_ptr    = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m0_bus_enable = 1'b0;
    m1_bus_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int m, input tb_req_t r, input logic en);
    if (m == 0) begin
      m0_address = r.addr; m0_rw = r.rw; m0_byte_enable = r.be;
      m0_write_data = r.wdata; m0_bus_enable = en;
    end else begin
      m1_address = r.addr; m1_rw = r.rw; m1_byte_enable = r.be;
      m1_write_data = r.wdata; m1_bus_enable = en;
    end
  endtask

  task automatic set_en(input int m, input logic en);
    if (m == 0) m0_bus_enable = en;
    else        m1_bus_enable = en;
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_acknowledge : m1_acknowledge;
  endfunction

  function automatic logic [15:0] rd_of(input int m);
    return (m == 0) ? m0_read_data : m1_read_data;
  endfunction

  function automatic tb_req_t mk(input logic [10:0] a, input logic rw,
                                 input logic [1:0] be, input logic [15:0] d);
    tb_req_t r;
    r.addr = a; r.rw = rw; r.be = be; r.wdata = d;
    return r;
  endfunction

  // Apply one completed transfer to the model and queue the expected read_data
  task automatic model_apply(input int m, input tb_req_t r);
    logic [9:0] w;
    w = r.addr[10:1];
    if (!r.rw) begin
      for (int l = 0; l < 2; l++) begin
        if (r.be[l]) mdl_mem[w][l*8 +: 8] = r.wdata[l*8 +: 8];
      end
      mdl_lanes[w] = mdl_lanes[w] | r.be;
      if (m == 1 && w == 10'h3FE) mdl_irq[0] = 1'b1;
      if (m == 0 && w == 10'h3FF) mdl_irq[1] = 1'b1;
    end else begin
      mdl_rd[m] = mdl_mem[w];
      if (m == 0 && w == 10'h3FE) mdl_irq[0] = 1'b0;
      if (m == 1 && w == 10'h3FF) mdl_irq[1] = 1'b0;
    end
    mdl_ptr = 1 - m;
    exp_q.push_back(mdl_rd[m]);
  endtask

  task automatic check_resp(input int m);
    logic [15:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (rd_of(m) !== exp) begin
      errors++;
      $display("FAIL read_data m%0d: got %h, expected %h", m, rd_of(m), exp);
    end
    checks++;
    if (m0_irq !== mdl_irq[0]) begin
      errors++;
      $display("FAIL m0_irq: got %b, expected %b", m0_irq, mdl_irq[0]);
    end
    checks++;
    if (m1_irq !== mdl_irq[1]) begin
      errors++;
      $display("FAIL m1_irq: got %b, expected %b", m1_irq, mdl_irq[1]);
    end
  endtask

  // Wait (bounded) for any acknowledge; who=-1 on timeout
  task automatic wait_ack(output int who, output int cyc);
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (m0_acknowledge) who = 0;
      else if (m1_acknowledge) who = 1;
    end
    checks++;
    if (who < 0) begin
      errors++;
      $display("FAIL ack_timeout: no acknowledge within %0d cycles", cyc);
    end
  endtask

  // One uncontended transfer; keep bus_enable high for 'hold' cycles after ack
  task automatic single(input int m, input tb_req_t r, input int hold);
    int who, cyc;
    drive(m, r, 1'b1);
    wait_ack(who, cyc);
    if (who >= 0) begin
      checks++;
      if (who != m || cyc != 3) begin
        errors++;
        $display("FAIL ack_latency: master %0d after %0d edges, expected master %0d after 3",
                 who, cyc, m);
      end
      model_apply(who, r);
      check_resp(who);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ack_of(m) !== 1'b0 || dbg_state !== RELEASE) begin
        errors++;
        $display("FAIL held_request: ack=%b state=%0d, expected ack=0 state=%0d",
                 ack_of(m), dbg_state, RELEASE);
      end
    end
    set_en(m, 1'b0);
    @(posedge clk); #1;
  endtask

  // Both masters request in the same cycle; pointer decides who goes first
  task automatic pair(input tb_req_t r0, input tb_req_t r1);
    int who, cyc, first;
    first = mdl_ptr;
    drive(0, r0, 1'b1);
    drive(1, r1, 1'b1);
    wait_ack(who, cyc);
    checks++;
    if (who != first || cyc != 3) begin
      errors++;
      $display("FAIL arb_first: master %0d after %0d edges, expected master %0d after 3",
               who, cyc, first);
    end
    if (who < 0) begin
      set_en(0, 1'b0); set_en(1, 1'b0);
      @(posedge clk); #1;
      return;
    end
    model_apply(who, (who != 0) ? r1 : r0);
    check_resp(who);
    set_en(who, 1'b0);
    wait_ack(who, cyc);
    checks++;
    if (who != 1 - first || cyc != 4) begin
      errors++;
      $display("FAIL arb_second: master %0d after %0d edges, expected master %0d after 4",
               who, cyc, 1 - first);
    end
    if (who >= 0) begin
      model_apply(who, (who != 0) ? r1 : r0);
      check_resp(who);
    end
    set_en(0, 1'b0); set_en(1, 1'b0);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (m0_acknowledge !== 1'b0 || m1_acknowledge !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b%b, expected 00", m1_acknowledge, m0_acknowledge);
    end
    checks++;
    if (m0_read_data !== 16'h0 || m1_read_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h, expected 0000/0000", m0_read_data, m1_read_data);
    end
    checks++;
    if (m0_irq !== 1'b0 || m1_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b%b, expected 00", m1_irq, m0_irq);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_write_read();
    single(0, mk(11'h010, 1'b0, 2'b11, 16'hBEEF), 0);
    single(0, mk(11'h010, 1'b1, 2'b11, 16'h0000), 0);
    checks++;
    if (m0_read_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_read: got %h, expected beef", m0_read_data);
    end
  endtask

  task automatic test_byte_lanes();
    single(1, mk(11'h020, 1'b0, 2'b11, 16'h1234), 0);
    single(1, mk(11'h020, 1'b0, 2'b10, 16'hAB00), 0);
    single(1, mk(11'h021, 1'b1, 2'b00, 16'h0000), 0);
    checks++;
    if (m1_read_data !== 16'hAB34) begin
      errors++;
      $display("FAIL byte_lanes: got %h, expected ab34", m1_read_data);
    end
    // be=00 write is acknowledged but leaves the word unchanged
    single(1, mk(11'h020, 1'b0, 2'b00, 16'hFFFF), 0);
    single(1, mk(11'h020, 1'b1, 2'b11, 16'h0000), 0);
  endtask

  task automatic test_contention();
    do_reset();
    pair(mk(11'h030, 1'b0, 2'b11, 16'h1111), mk(11'h032, 1'b0, 2'b11, 16'h2222));
    pair(mk(11'h032, 1'b1, 2'b11, 16'h0000), mk(11'h030, 1'b1, 2'b11, 16'h0000));
    single(0, mk(11'h034, 1'b0, 2'b11, 16'h3333), 0);
    pair(mk(11'h030, 1'b0, 2'b11, 16'h4444), mk(11'h030, 1'b0, 2'b11, 16'h5555));
    single(0, mk(11'h030, 1'b1, 2'b11, 16'h0000), 0);
  endtask

  task automatic test_held();
    single(0, mk(11'h040, 1'b0, 2'b11, 16'hC0DE), 5);
    single(0, mk(11'h040, 1'b1, 2'b11, 16'h0000), 5);
  endtask

  task automatic test_mailbox();
    single(1, mk(11'h7FC, 1'b0, 2'b11, 16'h0055), 0);
    checks++;
    if (m0_irq !== 1'b1) begin
      errors++;
      $display("FAIL mbox_set: m0_irq=%b, expected 1", m0_irq);
    end
    single(0, mk(11'h7FC, 1'b1, 2'b11, 16'h0000), 0);
    checks++;
    if (m0_read_data !== 16'h0055 || m0_irq !== 1'b0) begin
      errors++;
      $display("FAIL mbox_read: data=%h irq=%b, expected 0055 and 0", m0_read_data, m0_irq);
    end
    single(1, mk(11'h7FD, 1'b0, 2'b01, 16'h0066), 0);
    single(0, mk(11'h7FC, 1'b0, 2'b11, 16'h0099), 0);
    single(0, mk(11'h7FC, 1'b1, 2'b11, 16'h0000), 0);
    single(0, mk(11'h7FE, 1'b0, 2'b11, 16'h00AA), 0);
    single(1, mk(11'h7FE, 1'b0, 2'b11, 16'h00BB), 0);
    single(1, mk(11'h7FF, 1'b1, 2'b11, 16'h0000), 0);
  endtask

  task automatic test_reset_midop();
    // Reset while a write is in ACCESS: the write must be abandoned
    drive(0, mk(11'h010, 1'b0, 2'b11, 16'h5A5A), 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== IDLE || m0_acknowledge !== 1'b0) begin
      errors++;
      $display("FAIL reset_access: state=%0d ack=%b, expected %0d and 0",
               dbg_state, m0_acknowledge, IDLE);
    end
    set_en(0, 1'b0);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    single(0, mk(11'h010, 1'b1, 2'b11, 16'h0000), 0);
    // Reset during ACK with m0_irq pending
    single(1, mk(11'h7FC, 1'b0, 2'b11, 16'h0077), 0);
    drive(0, mk(11'h020, 1'b1, 2'b11, 16'h0000), 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== ACK) begin
      errors++;
      $display("FAIL midop_state: got %0d, expected %0d", dbg_state, ACK);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m0_acknowledge !== 1'b0 || m0_irq !== 1'b0 || m1_irq !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_ack_cycle: ack=%b irq=%b%b state=%0d, expected 0 00 %0d",
               m0_acknowledge, m1_irq, m0_irq, dbg_state, IDLE);
    end
    reset_n = 1'b1;
    set_en(0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    single(1, mk(11'h020, 1'b1, 2'b11, 16'h0000), 0);
  endtask

  function automatic tb_req_t rand_req();
    tb_req_t r;
    logic [9:0] w;
    int k;
    k = $urandom_range(0, 9);
    if (k < 8)       w = 10'h100 + 10'(k);
    else if (k == 8) w = 10'h3FE;
    else             w = 10'h3FF;
    r.addr  = {w, 1'($urandom_range(0, 1))};
    r.rw    = 1'($urandom_range(0, 1));
    r.be    = 2'($urandom_range(0, 3));
    r.wdata = 16'($urandom);
    if (r.rw && mdl_lanes[w] != 2'b11) begin
      r.rw = 1'b0;
      r.be = 2'b11;
    end
    return r;
  endfunction

  task automatic test_random();
    tb_req_t r0, r1;
    int m;
    for (int i = 0; i < 8; i++) begin
      r0 = mk({10'h100 + 10'(i), 1'b0}, 1'b0, 2'b11, 16'($urandom));
      single($urandom_range(0, 1), r0, 0);
    end
    for (int i = 0; i < 60; i++) begin
      r0 = rand_req();
      r1 = rand_req();
      if ($urandom_range(0, 2) == 0) begin
        pair(r0, r1);
      end else begin
        m = $urandom_range(0, 1);
        single(m, r0, $urandom_range(0, 2));
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset_n = 1'b0;
    m0_address = '0; m0_bus_enable = 1'b0; m0_byte_enable = '0; m0_rw = 1'b0; m0_write_data = '0;
    m1_address = '0; m1_bus_enable = 1'b0; m1_byte_enable = '0; m1_rw = 1'b0; m1_write_data = '0;
    for (int i = 0; i < 1024; i++) begin
      mdl_mem[i]   = '0;
      mdl_lanes[i] = 2'b00;
    end
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_contention();
    test_held();
    test_mailbox();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
